// File: rtl/ascon_pkg.sv
// ascon_pkg: shared Ascon word/state types, forward and inverse 5-bit S-box tables, FSM encoding.
package ascon_pkg;
  localparam int WORD_WIDTH = 64;
  typedef logic [4:0][WORD_WIDTH-1:0] ascon_state_t;
  typedef logic [31:0][4:0] sbox_lut_t;
  typedef enum logic [1:0] {IDLE, RUN, DONE} sbox_fsm_e;
  // entry 31 first, entry 0 last
  localparam sbox_lut_t SBOX_LUT = {
    5'h17, 5'h0f, 5'h0a, 5'h16, 5'h19, 5'h01, 5'h0c, 5'h10,
    5'h18, 5'h11, 5'h0d, 5'h00, 5'h0e, 5'h07, 5'h13, 5'h1e,
    5'h1c, 5'h06, 5'h03, 5'h1d, 5'h12, 5'h08, 5'h05, 5'h1b,
    5'h02, 5'h09, 5'h15, 5'h1a, 5'h14, 5'h1f, 5'h0b, 5'h04
  };
  function automatic sbox_lut_t invert_lut(input sbox_lut_t f);
    sbox_lut_t r;
    r = '0;
    for (int i = 0; i < 32; i++) r[f[i]] = i[4:0];
    return r;
  endfunction
  localparam sbox_lut_t SBOX_INV_LUT = invert_lut(SBOX_LUT);
endpackage

// File: rtl/sbox_slice.sv
// sbox_slice: one combinational 5-bit Ascon S-box, forward or inverse.
module sbox_slice
  import ascon_pkg::*;
(
  input  logic [4:0] data,
  input  logic       inv,
  output logic [4:0] result
);
  assign result = inv ? SBOX_INV_LUT[data] : SBOX_LUT[data];
endmodule

// File: rtl/sbox_layer_folded.sv
// sbox_layer_folded: folded Ascon S-box layer, LANES slices per cycle, valid/ready on both sides.
// Define ASCON_SBOX_INV_EN to add the inv_i port and the inverse S-box.
module sbox_layer_folded
  import ascon_pkg::*;
#(
  parameter int LANES = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
`ifdef ASCON_SBOX_INV_EN
  input  logic         inv_i,
`endif
  input  logic         valid_i,
  output logic         ready_o,
  input  ascon_state_t state_array_i,
  output logic         valid_o,
  input  logic         ready_i,
  output ascon_state_t state_array_o,
  output logic         busy_o
);
  localparam int NCHUNK = WORD_WIDTH / LANES;
  localparam int CW = NCHUNK > 1 ? $clog2(NCHUNK) : 1;
  if (!(LANES inside {1, 2, 4, 8, 16, 32, 64}) || (WORD_WIDTH % LANES) != 0) begin : g_bad_lanes
    $error("sbox_layer_folded: illegal LANES value %0d", LANES);
  end
  sbox_fsm_e state, state_nxt;
  ascon_state_t work, work_nxt;
  logic [CW-1:0] cnt;
  logic [4:0][LANES-1:0] chunk, subst;
  logic inv_q, accept, last;
  int base;
  assign base = int'(cnt) * LANES;
  assign last = cnt == CW'(NCHUNK - 1);
  assign accept = valid_i & ready_o;
  assign state_array_o = work;
  always_comb begin
    for (int w = 0; w < 5; w++) chunk[w] = work[w][base +: LANES];
  end
  // bit l of x0 is the S-box MSB, bit l of x4 the LSB
  for (genvar l = 0; l < LANES; l++) begin : g_slice
    logic [4:0] y;
    sbox_slice u_slice (
      .data  ({chunk[0][l], chunk[1][l], chunk[2][l], chunk[3][l], chunk[4][l]}),
      .inv   (inv_q),
      .result(y)
    );
    assign {subst[0][l], subst[1][l], subst[2][l], subst[3][l], subst[4][l]} = y;
  end
  always_comb begin
    work_nxt = work;
    for (int w = 0; w < 5; w++) work_nxt[w][base +: LANES] = subst[w];
  end
  always_ff @(posedge clk_i) begin
    if (!rst_ni) state <= IDLE;
    else state <= state_nxt;
  end
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    state_nxt = accept ? RUN : IDLE;
      RUN:     state_nxt = last ? DONE : RUN;
      DONE:    state_nxt = ready_i ? (valid_i ? RUN : IDLE) : DONE;
      default: state_nxt = IDLE;
    endcase
  end
  // ready_o combinationally follows ready_i in DONE so retire and capture share one edge
  always_comb begin
    ready_o = state == IDLE || (state == DONE && ready_i);
    valid_o = state == DONE;
    busy_o  = state == RUN;
  end
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      work <= '0;
      cnt  <= '0;
    end else if (accept) begin
      work <= state_array_i;
      cnt  <= '0;
    end else if (state == RUN) begin
      work <= work_nxt;
      cnt  <= cnt + 1'b1;
    end
  end
`ifdef ASCON_SBOX_INV_EN
  always_ff @(posedge clk_i) begin
    if (!rst_ni) inv_q <= 1'b0;
    else if (accept) inv_q <= inv_i;
  end
`else
  assign inv_q = 1'b0;
`endif
endmodule
